// File: rtl/ssm_step_ctrl.sv
// ---------------------------------------------------------------------------
// ssm_step_ctrl
//
// Per-token sequencer for the Mamba-2 SSM step datapath. One token at a time
// is accepted (operands are captured by the datapath on in_latch). The block
// then runs the compute stages in order:
//   1. dA and dBx in parallel
//   2. state update h = dA*h + dBx
//   3. y reduction
// Finally it offers y downstream with a valid/ready handshake. Each wait
// state has a watchdog. On expiry the token is abandoned and a sticky error
// is raised.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   tok_valid / tok_ready  upstream token handshake (tok_ready = IDLE)
//   in_latch               operand capture strobe for the datapath
//   da_start, dbx_start    one-cycle starts for the dA / dBx stages
//   da_done, dbx_done      one-cycle done pulses from the dA / dBx stages
//   hupd_start, hupd_done  start / done for the state-update stage
//   y_start, y_done        start / done for the y reduction stage
//   y_valid / y_ready      downstream result handshake
//   busy                   sequencer is not idle
//   abort                  one-cycle pulse on watchdog expiry
//   err, err_clr           sticky watchdog error and its clear
//   tok_cnt                tokens completed (wraps)
// ---------------------------------------------------------------------------
module ssm_step_ctrl #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int TOK_CNT_W   = 16,
  parameter int TO_W        = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tok_valid,
  output logic                 tok_ready,
  output logic                 in_latch,
  output logic                 da_start,
  output logic                 dbx_start,
  input  logic                 da_done,
  input  logic                 dbx_done,
  output logic                 hupd_start,
  input  logic                 hupd_done,
  output logic                 y_start,
  input  logic                 y_done,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic                 busy,
  output logic                 abort,
  output logic                 err,
  input  logic                 err_clr,
  output logic [TOK_CNT_W-1:0] tok_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT_AB = 3'd2,
    HUPD    = 3'd3,
    WAIT_H  = 3'd4,
    YC      = 3'd5,
    WAIT_Y  = 3'd6,
    OUT     = 3'd7
  } state_t;

  localparam logic [TO_W-1:0]      WD_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]      WD_ONE  = TO_W'(1);
  localparam logic [TOK_CNT_W-1:0] CNT_ONE = TOK_CNT_W'(1);

  state_t          state_reg;
  logic [TO_W-1:0] wd_reg;
  logic [1:0]      seen_reg;   // bit 0: dA done seen, bit 1: dBx done seen
  logic [1:0]      done_ab;
  logic [1:0]      seen_now;
  logic            in_wait;
  logic            wd_expire;

  assign tok_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign in_latch  = tok_valid & tok_ready;

  // A done arriving this cycle counts together with an already-seen partner,
  // so the join completes in the cycle of the later pulse.
  assign done_ab = {dbx_done, da_done};
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_seen
      assign seen_now[gi] = seen_reg[gi] | done_ab[gi];
    end
  endgenerate

  assign in_wait   = (state_reg == WAIT_AB) || (state_reg == WAIT_H) ||
                     (state_reg == WAIT_Y);
  assign wd_expire = in_wait && (wd_reg == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      wd_reg     <= '0;
      seen_reg   <= '0;
      da_start   <= 1'b0;
      dbx_start  <= 1'b0;
      hupd_start <= 1'b0;
      y_start    <= 1'b0;
      y_valid    <= 1'b0;
      abort      <= 1'b0;
      err        <= 1'b0;
      tok_cnt    <= '0;
    end else begin
      // Starts and abort are single-cycle pulses by default.
      da_start   <= 1'b0;
      dbx_start  <= 1'b0;
      hupd_start <= 1'b0;
      y_start    <= 1'b0;
      abort      <= 1'b0;

      // The watchdog only counts while in a wait state. Every other state
      // holds it at zero, so entering a wait state always starts from zero.
      if (in_wait) begin
        wd_reg <= wd_reg + WD_ONE;
      end else begin
        wd_reg <= '0;
      end

      // Expiry wins over a simultaneous clear. A clear that coincides with
      // the visible abort pulse is also ignored.
      if (wd_expire) begin
        err <= 1'b1;
      end else if (err_clr && !abort) begin
        err <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (tok_valid) begin
            state_reg <= LAUNCH;
          end
        end

        LAUNCH: begin
          da_start  <= 1'b1;
          dbx_start <= 1'b1;
          seen_reg  <= '0;
          state_reg <= WAIT_AB;
        end

        WAIT_AB: begin
          if (wd_expire) begin
            abort     <= 1'b1;
            state_reg <= IDLE;
          end else if (&seen_now) begin
            state_reg <= HUPD;
          end else begin
            seen_reg <= seen_now;
          end
        end

        HUPD: begin
          hupd_start <= 1'b1;
          state_reg  <= WAIT_H;
        end

        WAIT_H: begin
          if (wd_expire) begin
            abort     <= 1'b1;
            state_reg <= IDLE;
          end else if (hupd_done) begin
            state_reg <= YC;
          end
        end

        YC: begin
          y_start   <= 1'b1;
          state_reg <= WAIT_Y;
        end

        WAIT_Y: begin
          if (wd_expire) begin
            abort     <= 1'b1;
            state_reg <= IDLE;
          end else if (y_done) begin
            y_valid   <= 1'b1;
            state_reg <= OUT;
          end
        end

        OUT: begin
          // No watchdog here: downstream backpressure may last indefinitely.
          if (y_ready) begin
            y_valid   <= 1'b0;
            tok_cnt   <= tok_cnt + CNT_ONE;
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
